data_mover_burst_slave: RTL

- Avalon-MM burst slave responder: the target end of the data mover's read/write masters inside soc_system.
- Backs an on-chip word buffer that the data mover writes into and reads back.
- Pipelined burst reads, single-cycle write beats, waitrequest flow control, sticky protocol-error flag.
- Exercises data mover transfers without going through HPS SDRAM.

---
 rtl/data_mover_burst_slave_if.sv | 42 ++++
 rtl/data_mover_burst_slave.sv | 139 +++++++++++++
 2 files changed

// File: rtl/data_mover_burst_slave_if.sv
// Avalon-MM burst interface between the data mover masters and the
// on-chip burst slave.
//   master modport : drives address/read/write/writedata/byteenable/burstcount
//   slave modport  : drives waitrequest/readdata/readdatavalid (+ response)
// Optional: avs_response exists only when DATA_MOVER_BURST_SLAVE_RESPONSE_EN
// is defined.
interface data_mover_burst_slave_if #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10,
   parameter int BURST_W = 5
);
   logic [ADDR_W-1:0]   avs_address;
   logic                avs_read;
   logic                avs_write;
   logic [DATA_W-1:0]   avs_writedata;
   logic [DATA_W/8-1:0] avs_byteenable;
   logic [BURST_W-1:0]  avs_burstcount;
   logic                avs_waitrequest;
   logic [DATA_W-1:0]   avs_readdata;
   logic                avs_readdatavalid;
`ifdef DATA_MOVER_BURST_SLAVE_RESPONSE_EN
   logic [1:0]          avs_response;
`endif

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
             avs_byteenable, avs_burstcount,
      input  avs_waitrequest, avs_readdata, avs_readdatavalid
`ifdef DATA_MOVER_BURST_SLAVE_RESPONSE_EN
      , input avs_response
`endif
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
             avs_byteenable, avs_burstcount,
      output avs_waitrequest, avs_readdata, avs_readdatavalid
`ifdef DATA_MOVER_BURST_SLAVE_RESPONSE_EN
      , output avs_response
`endif
   );
endinterface

// File: rtl/data_mover_burst_slave.sv
// Avalon-MM burst slave backed by an on-chip word buffer. Target end of the
// data mover read/write masters; lets transfers run without HPS SDRAM.
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-high
//   avs          : data_mover_burst_slave_if.slave (burst command/data bus)
//   protocol_err : sticky, set on read during a write burst or read+write
//                  together in IDLE; cleared only by reset
// Optional macro DATA_MOVER_BURST_SLAVE_RESPONSE_EN adds avs_response
// (00 OKAY for in-range beats, 11 DECODEERROR for out-of-range beats).
// Out-of-range words (>= MEM_WORDS) drop writes and read back as zero.
module data_mover_burst_slave #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int MEM_WORDS = 768,
   parameter int BURST_W   = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   data_mover_burst_slave_if.slave  avs,
   output logic                     protocol_err
);
   localparam int NBYTES = DATA_W / 8;
   localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_WORDS);

   typedef enum logic [1:0] {IDLE, WBURST, RBURST, RDRAIN} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   base;
   logic [BURST_W-1:0]  idx;
   logic [BURST_W-1:0]  len;
   logic                waitreq_q;
   logic                rdv_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
`ifdef DATA_MOVER_BURST_SLAVE_RESPONSE_EN
   logic [1:0]          resp_q;
`endif

   logic [DATA_W-1:0]   mem [MEM_WORDS];

   logic [BURST_W-1:0]  eff_n;
   logic [ADDR_W-1:0]   beat_addr;
   logic [ADDR_W-1:0]   wr_addr;
   logic                wr_en;
   logic                rd_issue;
   logic                rd_ok;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < MEM_LIM;
   endfunction

   // burstcount of 0 is taken as a single beat
   assign eff_n     = (avs.avs_burstcount == '0) ? BURST_W'(1) : avs.avs_burstcount;
   // beat address wraps modulo 2**ADDR_W through natural truncation
   assign beat_addr = base + ADDR_W'(idx);
   assign wr_addr   = (state == IDLE) ? avs.avs_address : beat_addr;
   assign wr_en     = avs.avs_write && ((state == IDLE) || (state == WBURST))
                      && in_range(wr_addr);
   assign rd_issue  = (state == RBURST);
   assign rd_ok     = rd_issue && in_range(beat_addr);

   // word buffer: byte-lane writes, contents not reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (avs.avs_byteenable[b])
               mem[wr_addr][b*8 +: 8] <= avs.avs_writedata[b*8 +: 8];
         end
      end
   end

   // Command FSM plus read output register. The accept cycle latches the
   // command; RBURST reads one word per cycle straight into the output
   // register, so beat i is presented at accept+2+i.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         base      <= '0;
         idx       <= '0;
         len       <= '0;
         waitreq_q <= 1'b0;
         rdv_q     <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
`ifdef DATA_MOVER_BURST_SLAVE_RESPONSE_EN
         resp_q    <= 2'b00;
`endif
      end else begin
         rdv_q   <= rd_issue;
         rdata_q <= rd_ok ? mem[beat_addr] : '0;
`ifdef DATA_MOVER_BURST_SLAVE_RESPONSE_EN
         resp_q  <= (rd_issue && !rd_ok) ? 2'b11 : 2'b00;
`endif
         case (state)
            IDLE: begin
               if (avs.avs_write) begin
                  // write wins over a simultaneous read
                  if (avs.avs_read) err_q <= 1'b1;
                  base <= avs.avs_address;
                  idx  <= BURST_W'(1);
                  len  <= eff_n;
                  if (eff_n > BURST_W'(1)) state <= WBURST;
               end else if (avs.avs_read) begin
                  base      <= avs.avs_address;
                  idx       <= '0;
                  len       <= eff_n;
                  waitreq_q <= 1'b1;
                  state     <= RBURST;
               end
            end
            WBURST: begin
               if (avs.avs_read) err_q <= 1'b1;
               if (avs.avs_write) begin
                  idx <= idx + 1'b1;
                  if (idx == len - 1'b1) state <= IDLE;
               end
            end
            RBURST: begin
               idx <= idx + 1'b1;
               if (idx == len - 1'b1) state <= RDRAIN;
            end
            RDRAIN: begin
               // last beat is on the bus this cycle
               waitreq_q <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign avs.avs_waitrequest   = waitreq_q;
   assign avs.avs_readdatavalid = rdv_q;
   assign avs.avs_readdata      = rdata_q;
`ifdef DATA_MOVER_BURST_SLAVE_RESPONSE_EN
   assign avs.avs_response      = resp_q;
`endif
   assign protocol_err          = err_q;
endmodule
